free_list: RTL and testbench
============================

FREE_LIST -- requirements
Module: free_list

Interface
REQ-001 Parameter NUM_PREGS, default 64, total physical registers; PR_WIDTH = $clog2(NUM_PREGS).
REQ-002 Parameter NUM_AREGS, default 32, architectural registers; list DEPTH = NUM_PREGS - NUM_AREGS (default 32).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 free_deq  input  1  rename/dispatch consumes the register shown on free_rd this cycle.
REQ-006 free_rd  output  PR_WIDTH  physical register at the head of the list.
REQ-007 free_empty  output  1  list holds no free register.
REQ-008 enq_valid  input  1  ROB commit returns a stale physical register.
REQ-009 enq_preg  input  PR_WIDTH  register being returned.
REQ-010 commit_alloc  input  1  ROB commits an instruction that allocated a register (rd != x0).
REQ-011 flush  input  1  mispredict recovery; restore list to committed state.
REQ-012 free_count  output  $clog2(DEPTH)+1  number of free entries.
REQ-013 overflow_err  output  1  sticky error flag.

Function
REQ-014 Storage: circular buffer of DEPTH entries, each PR_WIDTH bits; pointers head, tail, retire_head, each $clog2(DEPTH)+1 bits, the MSB being the wrap bit.
REQ-015 free_count = tail - head (modulo pointer width); free_empty = (free_count == 0).
REQ-016 free_rd = mem[head index], combinational, zero latency; free_rd = 0 when free_empty.
REQ-017 Dequeue: free_deq && !free_empty && !flush -> head advances by 1 at the next edge.
REQ-018 free_deq while free_empty SHALL be ignored: no pointer change, no error.
REQ-019 Enqueue: enq_valid && enq_preg != 0 && free_count < DEPTH -> mem[tail] <= enq_preg, tail advances by 1.
REQ-020 enq_preg == 0 SHALL be ignored silently, since p0 is never allocated.
REQ-021 Enqueue when free_count == DEPTH, with no same-cycle dequeue -> entry dropped and overflow_err set to 1; overflow_err holds until rst.
REQ-022 Simultaneous dequeue and enqueue: both SHALL occur, count unchanged; full and enqueue with a valid dequeue is legal.
REQ-023 Dequeue and enqueue with free_empty: enqueue only, no bypass; the new register is visible on free_rd the next cycle.
REQ-024 commit_alloc -> retire_head advances by 1 (wrapping); retire_head SHALL never pass head.
REQ-025 flush -> head <= retire_head, or retire_head+1 if commit_alloc in the same cycle; a dequeue in the flush cycle is dropped; an enqueue in the flush cycle is still performed.
REQ-026 All pointer arithmetic wraps modulo 2*DEPTH; index = pointer low bits.

Reset
REQ-027 On rst: mem[i] <= NUM_AREGS + i for i in 0..DEPTH-1; head <= 0; retire_head <= 0; tail <= DEPTH (wrap bit 1, index 0); overflow_err <= 0.
REQ-028 Post-reset outputs: free_count = DEPTH, free_empty = 0, free_rd = NUM_AREGS (32).
REQ-029 rst SHALL override all same-cycle free_deq, enq_valid, commit_alloc and flush.

Structure
REQ-030 NUM_PREGS, NUM_AREGS and PR_WIDTH come from rv32i_types; DEPTH and pointer widths are local parameters.
REQ-031 Single flat module; no sub-modules.

Verification
REQ-032 Reset, then 32 consecutive free_deq -> free_rd sequence 32..63; free_empty=1 after the 32nd; free_rd=0.
REQ-033 Empty, free_deq with enq_valid enq_preg=40 -> no dequeue; next cycle free_rd=40, free_count=1.
REQ-034 Full, enq_valid enq_preg=5 without free_deq -> overflow_err=1 and stays 1; with free_deq the same cycle -> accepted, count stays 32.
REQ-035 5 deqs (p32..p36), commit_alloc twice, then flush -> head=2, free_rd=34, free_count=30.
REQ-036 Flush with commit_alloc and free_deq in the same cycle -> head=retire_head+1, dequeue dropped.
REQ-037 enq_valid with enq_preg=0 -> no change to tail or count.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared RV32I core sizing constants used by the rename stage.
package rv32i_types;

  localparam int NUM_PREGS = 64;
  localparam int NUM_AREGS = 32;
  localparam int PR_WIDTH  = $clog2(NUM_PREGS);

endpackage

// File: rtl/free_list.sv
// Physical-register free list for renaming: a circular buffer with a speculative
// head, a committed retire_head for mispredict recovery, and a tail fed by ROB commit.
module free_list #(
  parameter  int NUM_PREGS = rv32i_types::NUM_PREGS,
  parameter  int NUM_AREGS = rv32i_types::NUM_AREGS,
  localparam int PR_WIDTH  = $clog2(NUM_PREGS),
  localparam int DEPTH     = NUM_PREGS - NUM_AREGS,
  localparam int PTR_W     = $clog2(DEPTH) + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                free_deq,
  output logic [PR_WIDTH-1:0] free_rd,
  output logic                free_empty,
  input  logic                enq_valid,
  input  logic [PR_WIDTH-1:0] enq_preg,
  input  logic                commit_alloc,
  input  logic                flush,
  output logic [PTR_W-1:0]    free_count,
  output logic                overflow_err
);

  localparam int IDX_W = PTR_W - 1;

  logic [PR_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    head, tail, retire_head, retire_nxt;
  logic                full, deq_fire, enq_req, enq_fire, enq_drop, commit_fire;

  always_comb begin
    free_count  = tail - head;
    free_empty  = (free_count == '0);
    full        = (free_count == PTR_W'(DEPTH));
    deq_fire    = free_deq && !free_empty && !flush;
    enq_req     = enq_valid && (enq_preg != '0);
    // A full list can still accept a return when a dequeue frees the slot this cycle.
    enq_fire    = enq_req && (!full || deq_fire);
    enq_drop    = enq_req && full && !deq_fire;
    // retire_head may only catch up to head, including a head moving this cycle.
    commit_fire = commit_alloc && ((retire_head != head) || deq_fire);
    retire_nxt  = commit_fire ? retire_head + PTR_W'(1) : retire_head;
    free_rd     = free_empty ? '0 : mem[head[IDX_W-1:0]];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[IDX_W'(i)] <= PR_WIDTH'(NUM_AREGS + i);
      end
      head         <= '0;
      retire_head  <= '0;
      tail         <= PTR_W'(DEPTH);
      overflow_err <= 1'b0;
    end else begin
      retire_head <= retire_nxt;
      if (flush) begin
        head <= retire_nxt;
      end else if (deq_fire) begin
        head <= head + PTR_W'(1);
      end
      if (enq_fire) begin
        mem[tail[IDX_W-1:0]] <= enq_preg;
        tail                 <= tail + PTR_W'(1);
      end
      if (enq_drop) begin
        overflow_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Directed bench for free_list: per-cycle vector table plus hand-written
// drain/refill sequences around the empty boundary.
module tb_free_list;

  localparam int PR_WIDTH = 6;
  localparam int CNT_W    = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                free_deq = 1'b0;
  logic [PR_WIDTH-1:0] free_rd;
  logic                free_empty;
  logic                enq_valid = 1'b0;
  logic [PR_WIDTH-1:0] enq_preg = '0;
  logic                commit_alloc = 1'b0;
  logic                flush = 1'b0;
  logic [CNT_W-1:0]    free_count;
  logic                overflow_err;

  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  free_list #(.NUM_PREGS(64), .NUM_AREGS(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .free_deq     (free_deq),
    .free_rd      (free_rd),
    .free_empty   (free_empty),
    .enq_valid    (enq_valid),
    .enq_preg     (enq_preg),
    .commit_alloc (commit_alloc),
    .flush        (flush),
    .free_count   (free_count),
    .overflow_err (overflow_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        rst;
    logic        deq;
    logic        enq;
    logic [5:0]  preg;
    logic        commit;
    logic        flush;
    int unsigned exp_rd;
    int unsigned exp_cnt;
    logic        exp_empty;
    logic        exp_err;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic drive(input logic r, input logic d, input logic e, input logic [5:0] p,
                       input logic c, input logic f);
    rst = r; free_deq = d; enq_valid = e; enq_preg = p; commit_alloc = c; flush = f;
    @(posedge clk);
    #1;
    rst = 0; free_deq = 0; enq_valid = 0; enq_preg = '0; commit_alloc = 0; flush = 0;
  endtask

  task automatic check_outs(input string name, input int unsigned rd, input int unsigned cnt,
                            input logic emp, input logic err);
    chk({name, ".free_rd"}, free_rd, rd);
    chk({name, ".free_count"}, free_count, cnt);
    chk({name, ".free_empty"}, free_empty, emp);
    chk({name, ".overflow_err"}, overflow_err, err);
  endtask

  task automatic add(input string n, input logic r, input logic d, input logic e,
                     input logic [5:0] p, input logic c, input logic f,
                     input int unsigned rd, input int unsigned cnt, input logic emp,
                     input logic err);
    vec_t v;
    v.name = n; v.rst = r; v.deq = d; v.enq = e; v.preg = p; v.commit = c; v.flush = f;
    v.exp_rd = rd; v.exp_cnt = cnt; v.exp_empty = emp; v.exp_err = err;
    vecs.push_back(v);
  endtask

  initial begin
    //   name                 rst deq enq preg com fl   rd  cnt emp err
    add("reset",              1,  0,  0,  0,   0,  0,   32, 32, 0,  0);
    add("rst_override",       1,  1,  1,  5,   1,  1,   32, 32, 0,  0);
    add("overflow",           0,  0,  1,  5,   0,  0,   32, 32, 0,  1);
    add("overflow_sticky",    0,  0,  0,  0,   0,  0,   32, 32, 0,  1);
    add("full_deq_enq",       0,  1,  1,  5,   0,  0,   33, 32, 0,  1);
    add("reset_clears_err",   1,  0,  0,  0,   0,  0,   32, 32, 0,  0);
    add("commit_no_pass",     0,  0,  0,  0,   1,  0,   32, 32, 0,  0);
    add("deq_a",              0,  1,  0,  0,   0,  0,   33, 31, 0,  0);
    add("flush_retire_held",  0,  0,  0,  0,   0,  1,   32, 32, 0,  0);
    add("deq1",               0,  1,  0,  0,   0,  0,   33, 31, 0,  0);
    add("deq2",               0,  1,  0,  0,   0,  0,   34, 30, 0,  0);
    add("deq3",               0,  1,  0,  0,   0,  0,   35, 29, 0,  0);
    add("deq4",               0,  1,  0,  0,   0,  0,   36, 28, 0,  0);
    add("deq5",               0,  1,  0,  0,   0,  0,   37, 27, 0,  0);
    add("commit1",            0,  0,  0,  0,   1,  0,   37, 27, 0,  0);
    add("commit2",            0,  0,  0,  0,   1,  0,   37, 27, 0,  0);
    add("flush_to_retire",    0,  0,  0,  0,   0,  1,   34, 30, 0,  0);
    add("deq6",               0,  1,  0,  0,   0,  0,   35, 29, 0,  0);
    add("deq7",               0,  1,  0,  0,   0,  0,   36, 28, 0,  0);
    add("flush_commit_deq",   0,  1,  0,  0,   1,  1,   35, 29, 0,  0);
    add("enq7",               0,  0,  1,  7,   0,  0,   35, 30, 0,  0);
    add("deq_enq9",           0,  1,  1,  9,   0,  0,   36, 30, 0,  0);
    add("enq_zero",           0,  0,  1,  0,   0,  0,   36, 30, 0,  0);
    add("flush_with_enq",     0,  0,  1,  11,  0,  1,   35, 32, 0,  0);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].deq, vecs[i].enq, vecs[i].preg, vecs[i].commit, vecs[i].flush);
      check_outs(vecs[i].name, vecs[i].exp_rd, vecs[i].exp_cnt, vecs[i].exp_empty,
                 vecs[i].exp_err);
    end

    // Drain the whole list from reset: heads come out in reset order 32..63.
    drive(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 32; i++) begin
      chk($sformatf("drain_rd%0d", i), free_rd, 32 + i);
      drive(0, 1, 0, 0, 0, 0);
    end
    check_outs("drained", 0, 0, 1, 0);

    drive(0, 1, 0, 0, 0, 0);
    check_outs("deq_on_empty", 0, 0, 1, 0);

    drive(0, 1, 1, 6'd40, 0, 0);
    check_outs("empty_deq_enq40", 40, 1, 0, 0);

    drive(0, 0, 1, 6'd0, 0, 0);
    check_outs("enq_zero_empty", 40, 1, 0, 0);

    drive(0, 1, 0, 0, 0, 0);
    check_outs("redrain", 0, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
